// File: rtl/inv_diffusion.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | inv_diffusion: InvMixColumns then InvShiftRows on a 4x4 byte state,      |
// | COLS_PER_CYCLE columns per clock, valid/ready on both ends.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module inv_diffusion #(
    parameter int         COLS_PER_CYCLE = 1,
    parameter logic [7:0] REDUCE_POLY    = 8'h1B
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_skip_mix,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int         NUM_STEPS = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] LAST_STEP = 2'(NUM_STEPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MIX  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [127:0] work_q, work_d;
    logic         skip_q, skip_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [127:0] out_state_q, out_state_d;
    logic         out_valid_q, out_valid_d;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? REDUCE_POLY : 8'h00);
    endfunction

    // Column packed as {a3, a2, a1, a0}, top row in the high byte.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[8*i +: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[3] ^ mb[2] ^ md[1] ^ m9[0],
                m9[3] ^ me[2] ^ mb[1] ^ md[0],
                md[3] ^ m9[2] ^ me[1] ^ mb[0],
                mb[3] ^ md[2] ^ m9[1] ^ me[0]};
    endfunction

    function automatic logic [31:0] get_col(input logic [127:0] s, input logic [1:0] idx);
        logic [31:0] col;
        col = '0;
        for (int c = 0; c < 4; c++) begin
            if (idx == 2'(c)) begin
                col = {s[8*(12+c) +: 8], s[8*(8+c) +: 8], s[8*(4+c) +: 8], s[8*c +: 8]};
            end
        end
        return col;
    endfunction

    // Row r rotates by (3 - r): row 3 fixed, row 0 picks from column c-1.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] res;
        int           src;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                src = (c + 3 - r) % 4;
                res[8*(4*r+c) +: 8] = s[8*(4*r+src) +: 8];
            end
        end
        return res;
    endfunction

    logic [1:0]  lane_col [COLS_PER_CYCLE];
    logic [31:0] lane_out [COLS_PER_CYCLE];

    genvar j;
    generate
        for (j = 0; j < COLS_PER_CYCLE; j++) begin : g_lane
            assign lane_col[j] = 2'(3 - int'(cnt_q) * COLS_PER_CYCLE - j);
            assign lane_out[j] = inv_mix_col(get_col(work_q, lane_col[j]));
        end
    endgenerate

    logic [127:0] mixed;

    always_comb begin
        mixed = work_q;
        if (!skip_q) begin
            for (int l = 0; l < COLS_PER_CYCLE; l++) begin
                for (int c = 0; c < 4; c++) begin
                    if (lane_col[l] == 2'(c)) begin
                        mixed[8*(12+c) +: 8] = lane_out[l][31:24];
                        mixed[8*(8+c)  +: 8] = lane_out[l][23:16];
                        mixed[8*(4+c)  +: 8] = lane_out[l][15:8];
                        mixed[8*c      +: 8] = lane_out[l][7:0];
                    end
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        skip_d      = skip_q;
        cnt_d       = cnt_q;
        out_state_d = out_state_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    work_d  = in_state;
                    skip_d  = in_skip_mix;
                    cnt_d   = 2'd0;
                    state_d = ST_MIX;
                end
            end
            ST_MIX: begin
                work_d = mixed;
                if (cnt_q == LAST_STEP) begin
                    out_state_d = inv_shift_rows(mixed);
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            work_q      <= '0;
            skip_q      <= 1'b0;
            cnt_q       <= 2'd0;
            out_state_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            skip_q      <= skip_d;
            cnt_q       <= cnt_d;
            out_state_q <= out_state_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_state = out_state_q;

endmodule
`default_nettype wire

// File: tb/tb_inv_diffusion.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_inv_diffusion: checks inv_diffusion at 1, 2 and 4 columns per cycle   |
// | against a byte-matrix reference model. Revision: 1.0                     |
// +--------------------------------------------------------------------------+
module tb_inv_diffusion;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_skip_mix = 1'b0;
    logic         out_ready = 1'b1;
    logic [127:0] in_state = '0;
    logic [2:0]   ir, ov, bz;
    logic [127:0] os [3];

    int n_cmp = 0;
    int n_bad = 0;

    inv_diffusion #(.COLS_PER_CYCLE(1)) u_c1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir[0]),
        .in_state(in_state), .in_skip_mix(in_skip_mix), .out_valid(ov[0]),
        .out_ready(out_ready), .out_state(os[0]), .busy(bz[0]));
    inv_diffusion #(.COLS_PER_CYCLE(2)) u_c2 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir[1]),
        .in_state(in_state), .in_skip_mix(in_skip_mix), .out_valid(ov[1]),
        .out_ready(out_ready), .out_state(os[1]), .busy(bz[1]));
    inv_diffusion #(.COLS_PER_CYCLE(4)) u_c4 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir[2]),
        .in_state(in_state), .in_skip_mix(in_skip_mix), .out_valid(ov[2]),
        .out_ready(out_ready), .out_state(os[2]), .busy(bz[2]));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    // Latency in edges: 4 columns / columns per cycle.
    function automatic int lat_of(input int i);
        return 4 >> i;
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_model(input logic [127:0] s, input bit skip);
        logic [7:0]   m [4][4];
        logic [7:0]   a3, a2, a1, a0;
        logic [127:0] res;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m[r][c] = s[8*(4*r+c) +: 8];
        if (!skip) begin
            for (int c = 0; c < 4; c++) begin
                a3 = m[3][c]; a2 = m[2][c]; a1 = m[1][c]; a0 = m[0][c];
                m[3][c] = gmul(8'h0e, a3) ^ gmul(8'h0b, a2) ^ gmul(8'h0d, a1) ^ gmul(8'h09, a0);
                m[2][c] = gmul(8'h09, a3) ^ gmul(8'h0e, a2) ^ gmul(8'h0b, a1) ^ gmul(8'h0d, a0);
                m[1][c] = gmul(8'h0d, a3) ^ gmul(8'h09, a2) ^ gmul(8'h0e, a1) ^ gmul(8'h0b, a0);
                m[0][c] = gmul(8'h0b, a3) ^ gmul(8'h0d, a2) ^ gmul(8'h09, a1) ^ gmul(8'h0e, a0);
            end
        end
        res = '0;
        for (int c = 0; c < 4; c++) begin
            res[8*(12+c) +: 8] = m[3][c];
            res[8*(8+c)  +: 8] = m[2][(c + 1) % 4];
            res[8*(4+c)  +: 8] = m[1][(c + 2) % 4];
            res[8*c      +: 8] = m[0][(c + 3) % 4];
        end
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (ir !== 3'b111 && g < 20) begin
            tick();
            g++;
        end
        n_cmp++;
        if (ir !== 3'b111) begin
            n_bad++;
            $display("FAIL wait_idle: in_ready=%b required=111", ir);
        end
    endtask

    // One transaction on all three engines with out_ready held high.
    task automatic run_txn(input logic [127:0] st, input bit skip, input logic [127:0] want,
                           input string name);
        bit seen [3];
        wait_idle();
        in_valid    = 1'b1;
        in_state    = st;
        in_skip_mix = skip;
        tick();
        in_valid    = 1'b0;
        in_state    = rand128();
        in_skip_mix = ~skip;
        n_cmp++;
        if (bz !== 3'b111 || ir !== 3'b000 || ov !== 3'b000) begin
            n_bad++;
            $display("FAIL %s accept: busy=%b in_ready=%b out_valid=%b required 111/000/000",
                     name, bz, ir, ov);
        end
        for (int i = 0; i < 3; i++) seen[i] = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                if (!seen[i] && ov[i] === 1'b1) begin
                    seen[i] = 1'b1;
                    n_cmp++;
                    if (os[i] !== want) begin
                        n_bad++;
                        $display("FAIL %s data cpc_idx=%0d: got=%h required=%h", name, i, os[i], want);
                    end
                    n_cmp++;
                    if (e != lat_of(i)) begin
                        n_bad++;
                        $display("FAIL %s latency cpc_idx=%0d: got=%0d required=%0d", name, i, e, lat_of(i));
                    end
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (!seen[i]) begin
                n_bad++;
                $display("FAIL %s timeout cpc_idx=%0d: out_valid never rose, required within %0d edges",
                         name, i, lat_of(i));
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        n_cmp++;
        if (ov !== 3'b000 || bz !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_ctrl: out_valid=%b busy=%b required 000/000", ov, bz);
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (os[i] !== 128'h0) begin
                n_bad++;
                $display("FAIL reset_data cpc_idx=%0d: got=%h required=0", i, os[i]);
            end
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        n_cmp++;
        if (ir !== 3'b111 || bz !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_release: in_ready=%b busy=%b required 111/000", ir, bz);
        end
    endtask

    task automatic test_vectors();
        run_txn(128'h8e8e8e8e_4d4d4d4d_a1a1a1a1_bcbcbcbc, 1'b0,
                128'hdbdbdbdb_13131313_53535353_45454545, "t1_mix");
        run_txn(128'h00010203_10111213_20212223_30313233, 1'b1,
                128'h00010203_13101112_22232021_31323330, "t2_shift");
        run_txn({16{8'h01}}, 1'b0, {16{8'h01}}, "t3_ones");
        run_txn(128'h80808080_00000000_00000000_00000000, 1'b0,
                128'h41414141_ecececec_dadadada_f7f7f7f7, "t3_reduce");
    endtask

    task automatic test_random();
        logic [127:0] st;
        bit           sk;
        for (int n = 0; n < 8; n++) begin
            st = rand128();
            sk = ($urandom() % 4) == 0;
            run_txn(st, sk, ref_model(st, sk), "random");
        end
    endtask

    task automatic test_hold();
        logic [127:0] a, want;
        a    = rand128();
        want = ref_model(a, 1'b0);
        wait_idle();
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        in_state    = a;
        in_skip_mix = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        for (int c = 0; c < 10; c++) begin
            in_valid    = 1'b1;
            in_state    = rand128();
            in_skip_mix = c[0];
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (os[i] !== want || ov[i] !== 1'b1 || ir[i] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL hold cpc_idx=%0d cyc=%0d: data=%h valid=%b ready=%b required %h/1/0",
                             i, c, os[i], ov[i], ir[i], want);
                end
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        n_cmp++;
        if (ov !== 3'b000 || ir !== 3'b111 || bz !== 3'b000) begin
            n_bad++;
            $display("FAIL hold_release: out_valid=%b in_ready=%b busy=%b required 000/111/000", ov, ir, bz);
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (os[i] !== want) begin
                n_bad++;
                $display("FAIL hold_keep cpc_idx=%0d: got=%h required=%h", i, os[i], want);
            end
        end
    endtask

    task automatic test_reset_mid();
        wait_idle();
        in_valid    = 1'b1;
        in_state    = 128'h8e8e8e8e_4d4d4d4d_a1a1a1a1_bcbcbcbc;
        in_skip_mix = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (ov !== 3'b000 || bz !== 3'b000) begin
            n_bad++;
            $display("FAIL midreset_ctrl: out_valid=%b busy=%b required 000/000", ov, bz);
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (os[i] !== 128'h0) begin
                n_bad++;
                $display("FAIL midreset_data cpc_idx=%0d: got=%h required=0", i, os[i]);
            end
        end
        tick();
        reset_n = 1'b1;
        run_txn(128'h8e8e8e8e_4d4d4d4d_a1a1a1a1_bcbcbcbc, 1'b0,
                128'hdbdbdbdb_13131313_53535353_45454545, "t5_after_reset");
    endtask

    // Streaming: each engine spends N mix edges, one done edge, one idle edge per result.
    task automatic test_back_to_back();
        int           acc [3];
        int           due [3];
        logic [127:0] exp_out [3];
        logic [127:0] st;
        bit           sk;
        wait_idle();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            acc[i] = 0;
            due[i] = -1;
        end
        for (int t = 0; t < 40; t++) begin
            st          = rand128();
            sk          = $urandom() % 2;
            in_valid    = 1'b1;
            in_state    = st;
            in_skip_mix = sk;
            tick();
            for (int i = 0; i < 3; i++) begin
                if (t == acc[i]) begin
                    exp_out[i] = ref_model(st, sk);
                    due[i]     = t + lat_of(i);
                    acc[i]     = t + lat_of(i) + 2;
                end
                n_cmp++;
                if (ov[i] !== (t == due[i])) begin
                    n_bad++;
                    $display("FAIL stream_valid cpc_idx=%0d t=%0d: got=%b required=%b", i, t, ov[i], t == due[i]);
                end
                if (t == due[i]) begin
                    n_cmp++;
                    if (os[i] !== exp_out[i]) begin
                        n_bad++;
                        $display("FAIL stream_data cpc_idx=%0d t=%0d: got=%h required=%h", i, t, os[i], exp_out[i]);
                    end
                end
            end
        end
        in_valid = 1'b0;
        repeat (6) tick();
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
